coin_validator: RTL and testbench
=================================

Name: coin_validator

Overview:
Front end of the coffee-machine controller. Takes the raw, asynchronous, bouncing 50-ban and 100-ban coin-slot sensor lines and turns them into clean single-cycle pulses. Its bani50 and bani100 outputs drive the vending FSM's coin inputs directly. Both pulses in the same cycle is legal; the FSM credits 150. The block also flags a jammed coin.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles required to accept a level change (>=1)
JAM_CYCLES, 64, cycles a coin may stay present after acceptance before coin_jam asserts (must be > DEBOUNCE_CYCLES)

Ports:
clock  input  1  system clock, all state on posedge
reset  input  1  asynchronous, active-high reset
senzor50_raw  input  1  raw 50-ban slot sensor; asynchronous; high = coin present
senzor100_raw  input  1  raw 100-ban slot sensor; asynchronous; high = coin present
bani50  output  1  one-cycle pulse per accepted 50-ban coin
bani100  output  1  one-cycle pulse per accepted 100-ban coin
coin_jam  output  1  level; OR of both channels' jam flags

Behaviour:
- Two identical independent channels. Each channel has:
  - a 2-flop synchronizer;
  - a counter sized $clog2(JAM_CYCLES+1), saturating, never wraps;
  - a registered state machine.
- Reset:
  - All outputs are 0 immediately (async).
  - Synchronizer flops reset to 1. Each channel's state resets to RELEASE with counter 0.
  - Consequence: a coin held across reset is never credited. The line must be seen low for DEBOUNCE_CYCLES before the channel arms.
- States; s is the synchronized sensor level:
  - IDLE:
    - s=1 -> DEB_HI, cnt=1.
  - DEB_HI:
    - s=0 -> IDLE, cnt=0. Glitch; no pulse.
    - s=1 and cnt==DEBOUNCE_CYCLES -> ACCEPTED, cnt=0, channel pulse register set for exactly one cycle.
    - Otherwise cnt+1.
  - ACCEPTED:
    - s=0 -> RELEASE, cnt=1.
    - Otherwise cnt+1 (saturating).
    - When cnt reaches JAM_CYCLES, the channel jam flag is set.
  - RELEASE:
    - s=1 -> ACCEPTED, cnt=0. Bounce on removal; no new pulse; jam flag unchanged.
    - s=0 and cnt==DEBOUNCE_CYCLES -> IDLE, jam flag cleared.
    - Otherwise cnt+1.
- Latency: with the raw line stable high from the first posedge that samples it high (edge 0), the pulse is high during the cycle after edge DEBOUNCE_CYCLES+2. With default parameters that is edge 6.
- Pulse width is exactly 1 cycle, at most one pulse per insertion, and outputs are registered.
- Jam timing:
  - coin_jam rises JAM_CYCLES cycles after the channel's pulse cycle, if the coin stays present.
  - It falls DEBOUNCE_CYCLES+2 cycles after the first edge sampling the raw line low.
- Simultaneous events:
  - Channels never interact; both pulses may coincide.
  - A jam on one channel does not block the other.
- No input combination is illegal. Bounce is filtered and never produces an extra pulse.

Decomposition:
- Package coin_pkg holds:
  - typedef enum logic [1:0] coin_state_t {IDLE, DEB_HI, ACCEPTED, RELEASE};
  - the counter-width function.
- Sub-module coin_channel (synchronizer, counter, state machine, pulse register, jam flag) is instantiated twice in coin_validator.
- The top level only ORs the jam flags.

Test Plan (defaults DEBOUNCE_CYCLES=4, JAM_CYCLES=64; edges counted from first high-sampling edge = 0):
1. Release reset, hold raws low 10 cycles, then senzor50_raw high 12 cycles -> bani50 high only in the cycle after edge 6; bani100 and coin_jam stay 0.
2. senzor100_raw high 3 cycles then low -> no bani100 pulse; a clean 12-cycle insertion afterwards gives exactly one pulse.
3. Both raws high together for 12 cycles -> bani50 and bani100 pulse in the same cycle, once each.
4. senzor50_raw high 10, low 2, high 2, low 10 -> exactly one bani50 pulse; a next clean insertion is accepted.
5. Jam and reset mid-operation:
   - senzor100_raw high 80 cycles -> one pulse after edge 6, coin_jam rises at edge 70. After release, coin_jam falls 6 edges after the first low sample and a new insertion pulses normally.
   - Assert reset mid-insertion with the raw line still high, then deassert -> no pulse until the line is seen low ≥4 cycles and reinserted.

Source files
------------

// File: rtl/coin_pkg.sv
// Shared types and helpers for the coin-slot front end.
// Holds the per-channel state encoding and the debounce/jam counter width.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DEB_HI,
        ACCEPTED,
        RELEASE
    } coin_state_t;

    // The counter must be able to hold JAM_CYCLES itself, so it can saturate there.
    function automatic int cnt_width(input int jam_cycles);
        return $clog2(jam_cycles + 1);
    endfunction

endpackage

// File: rtl/coin_channel.sv
// One coin-slot channel: synchronizer, debounce/jam counter, state machine,
// a single-cycle acceptance pulse and a jam flag.
module coin_channel
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic sensor_raw,
    output logic pulse,
    output logic jam
);

    localparam int CW = cnt_width(JAM_CYCLES);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] JAM_MAX = CW'(JAM_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic        sync_meta_reg;
    logic        sync_reg;
    coin_state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] cnt_inc;
    logic        pulse_reg, pulse_next;
    logic        jam_reg, jam_next;

    // Synchronizer resets high so a coin already in the slot at reset looks present.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta_reg <= 1'b1;
            sync_reg      <= 1'b1;
        end else begin
            sync_meta_reg <= sensor_raw;
            sync_reg      <= sync_meta_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= RELEASE;
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
            jam_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            pulse_reg <= pulse_next;
            jam_reg   <= jam_next;
        end
    end

    assign cnt_inc = (cnt_reg == JAM_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        jam_next   = jam_reg;
        case (state_reg)
            IDLE: begin
                if (sync_reg) begin
                    state_next = DEB_HI;
                    cnt_next   = CNT_ONE;
                end
            end
            DEB_HI: begin
                if (!sync_reg) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_MAX) begin
                    state_next = ACCEPTED;
                    cnt_next   = '0;
                    pulse_next = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ACCEPTED: begin
                if (!sync_reg) begin
                    state_next = RELEASE;
                    cnt_next   = CNT_ONE;
                end else begin
                    cnt_next = cnt_inc;
                    if (cnt_inc == JAM_MAX) begin
                        jam_next = 1'b1;
                    end
                end
            end
            RELEASE: begin
                // A return to high here is removal bounce: no new pulse, jam kept.
                if (sync_reg) begin
                    state_next = ACCEPTED;
                    cnt_next   = '0;
                end else if (cnt_reg == DEB_MAX) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    jam_next   = 1'b0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = RELEASE;
                cnt_next   = '0;
            end
        endcase
    end

    assign pulse = pulse_reg;
    assign jam   = jam_reg;

endmodule

// File: rtl/coin_validator.sv
// Coin-slot front end: two independent debounced channels producing clean
// credit pulses, plus a combined jam indication.
module coin_validator
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int JAM_CYCLES      = 64
) (
    input  logic clock,
    input  logic reset,
    input  logic senzor50_raw,
    input  logic senzor100_raw,
    output logic bani50,
    output logic bani100,
    output logic coin_jam
);

    logic [1:0] raw_vec;
    logic [1:0] pulse_vec;
    logic [1:0] jam_vec;

    assign raw_vec = {senzor100_raw, senzor50_raw};

    // Index 0 is the 50-ban slot, index 1 the 100-ban slot.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_channel
            coin_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .JAM_CYCLES      (JAM_CYCLES)
            ) u_channel (
                .clock      (clock),
                .reset      (reset),
                .sensor_raw (raw_vec[gi]),
                .pulse      (pulse_vec[gi]),
                .jam        (jam_vec[gi])
            );
        end
    endgenerate

    assign bani50   = pulse_vec[0];
    assign bani100  = pulse_vec[1];
    assign coin_jam = |jam_vec;

endmodule

// File: tb/tb_coin_validator.sv
// Bench for coin_validator: directed scenarios plus randomized sensor traffic,
// checked every cycle against a run-length model of the slot behaviour.
module tb_coin_validator;

    localparam int DEB = 4;
    localparam int JAM = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic senzor50_raw = 1'b0;
    logic senzor100_raw = 1'b0;
    logic bani50;
    logic bani100;
    logic coin_jam;

    always #5 clock = ~clock;

    coin_validator #(
        .DEBOUNCE_CYCLES (DEB),
        .JAM_CYCLES      (JAM)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .senzor50_raw  (senzor50_raw),
        .senzor100_raw (senzor100_raw),
        .bani50        (bani50),
        .bani100       (bani100),
        .coin_jam      (coin_jam)
    );

    int checks = 0;
    int failures = 0;

    // Model: synchronized level seen through two flops, then run lengths of that level.
    logic m_meta[2];
    logic m_s[2];
    logic m_held[2];
    logic m_run_val[2];
    int   m_run_len[2];
    int   m_since[2];
    logic m_pulse[2];
    logic m_jam[2];

    int edge_no;
    int p_cnt[2];
    int first_p[2];
    int first_jam_hi;
    int first_jam_lo;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < 2; ch++) begin
            m_meta[ch]    = 1'b1;
            m_s[ch]       = 1'b1;
            m_held[ch]    = 1'b1;
            m_run_val[ch] = 1'b1;
            m_run_len[ch] = 0;
            m_since[ch]   = 0;
            m_pulse[ch]   = 1'b0;
            m_jam[ch]     = 1'b0;
        end
    endtask

    task automatic model_edge(input logic r50, input logic r100);
        logic raw[2];
        logic s;
        raw[0] = r50;
        raw[1] = r100;
        for (int ch = 0; ch < 2; ch++) begin
            s = m_s[ch];
            m_s[ch] = m_meta[ch];
            m_meta[ch] = raw[ch];
            m_pulse[ch] = 1'b0;
            if (s == m_run_val[ch]) begin
                if (m_run_len[ch] < 100000) m_run_len[ch]++;
            end else begin
                m_run_val[ch] = s;
                m_run_len[ch] = 1;
            end
            if (!m_held[ch]) begin
                // A coin counts once the level has been high for DEB+1 consecutive samples.
                if (s && m_run_len[ch] == DEB + 1) begin
                    m_pulse[ch] = 1'b1;
                    m_held[ch]  = 1'b1;
                    m_since[ch] = 0;
                end
            end else if (s) begin
                if (m_run_len[ch] == 1) m_since[ch] = 0;
                else if (m_since[ch] < JAM) m_since[ch]++;
                if (m_since[ch] >= JAM) m_jam[ch] = 1'b1;
            end else if (m_run_len[ch] == DEB + 1) begin
                m_held[ch] = 1'b0;
                m_jam[ch]  = 1'b0;
            end
        end
    endtask

    task automatic mark();
        edge_no = 0;
        for (int ch = 0; ch < 2; ch++) begin
            p_cnt[ch] = 0;
            first_p[ch] = -1;
        end
        first_jam_hi = -1;
        first_jam_lo = -1;
    endtask

    task automatic cycle(input logic r50, input logic r100);
        senzor50_raw  = r50;
        senzor100_raw = r100;
        @(posedge clock);
        model_edge(r50, r100);
        #1;
        check("bani50", bani50, m_pulse[0]);
        check("bani100", bani100, m_pulse[1]);
        check("coin_jam", coin_jam, m_jam[0] | m_jam[1]);
        if (bani50) begin
            p_cnt[0]++;
            if (first_p[0] < 0) first_p[0] = edge_no;
        end
        if (bani100) begin
            p_cnt[1]++;
            if (first_p[1] < 0) first_p[1] = edge_no;
        end
        if (coin_jam && first_jam_hi < 0) first_jam_hi = edge_no;
        if (!coin_jam && first_jam_lo < 0) first_jam_lo = edge_no;
        edge_no++;
    endtask

    task automatic run(input logic r50, input logic r100, input int n);
        for (int i = 0; i < n; i++) cycle(r50, r100);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_bani50", bani50, 0);
        check("rst_bani100", bani100, 0);
        check("rst_coin_jam", coin_jam, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic lvl[2];
        int   len[2];
        #2;
        apply_reset();

        // 1: single clean 50-ban insertion
        run(0, 0, 10);
        mark();
        run(1, 0, 12);
        run(0, 0, 10);
        check("t1_p50_count", p_cnt[0], 1);
        check("t1_p50_edge", first_p[0], DEB + 2);
        check("t1_p100_count", p_cnt[1], 0);
        check("t1_jam_seen", first_jam_hi, -1);
        $display("t1 clean 50: pulses=%0d at edge %0d", p_cnt[0], first_p[0]);

        // 2: short glitch on 100, then a clean insertion
        mark();
        run(0, 1, 3);
        run(0, 0, 10);
        check("t2_glitch_p100", p_cnt[1], 0);
        mark();
        run(0, 1, 12);
        run(0, 0, 10);
        check("t2_clean_p100", p_cnt[1], 1);
        $display("t2 glitch then clean 100: pulses=%0d", p_cnt[1]);

        // 3: both coins together
        mark();
        run(1, 1, 12);
        run(0, 0, 10);
        check("t3_p50_count", p_cnt[0], 1);
        check("t3_p100_count", p_cnt[1], 1);
        check("t3_p50_edge", first_p[0], DEB + 2);
        check("t3_p100_edge", first_p[1], DEB + 2);
        $display("t3 both: p50=%0d p100=%0d", p_cnt[0], p_cnt[1]);

        // 4: removal bounce
        mark();
        run(1, 0, 10);
        run(0, 0, 2);
        run(1, 0, 2);
        run(0, 0, 10);
        check("t4_bounce_p50", p_cnt[0], 1);
        mark();
        run(1, 0, 12);
        run(0, 0, 10);
        check("t4_next_p50", p_cnt[0], 1);
        $display("t4 bounce: p50=%0d", p_cnt[0]);

        // 5: jam on 100 and recovery
        mark();
        run(0, 1, 80);
        check("t5_p100_count", p_cnt[1], 1);
        check("t5_p100_edge", first_p[1], DEB + 2);
        check("t5_jam_rise", first_jam_hi, DEB + 2 + JAM);
        mark();
        run(0, 0, 10);
        check("t5_jam_fall", first_jam_lo, DEB + 2);
        mark();
        run(0, 1, 12);
        run(0, 0, 10);
        check("t5_after_jam_p100", p_cnt[1], 1);
        $display("t5 jam: rise/fall observed, post-jam pulses=%0d", p_cnt[1]);

        // 5b: reset while a coin is held in the slot
        run(1, 0, 3);
        apply_reset();
        mark();
        run(1, 0, 20);
        check("t5b_held_p50", p_cnt[0], 0);
        run(0, 0, 10);
        mark();
        run(1, 0, 12);
        run(0, 0, 10);
        check("t5b_reinsert_p50", p_cnt[0], 1);
        $display("t5b reset with coin held: reinsert pulses=%0d", p_cnt[0]);

        // Randomized traffic with bounces, long holds and occasional resets
        for (int ch = 0; ch < 2; ch++) begin
            lvl[ch] = 1'b0;
            len[ch] = 0;
        end
        for (int i = 0; i < 4000; i++) begin
            for (int ch = 0; ch < 2; ch++) begin
                if (len[ch] == 0) begin
                    lvl[ch] = ~lvl[ch];
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: len[ch] = $urandom_range(1, 3);
                        9:          len[ch] = $urandom_range(65, 90);
                        default:    len[ch] = $urandom_range(5, 15);
                    endcase
                end
                len[ch]--;
            end
            cycle(lvl[0], lvl[1]);
            if ($urandom_range(0, 499) == 0) apply_reset();
        end
        $display("random phase done: %0d checks so far", checks);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
